ysyx_ifu_sram_responder: RTL and testbench
==========================================

Name: ysyx_ifu_sram_responder

Overview:
Read-only instruction memory responder on the IFU fetch bus. It answers the fetch port (araddr/arvalid in, rdata/rvalid out) with a fixed, parameterised latency. One request is outstanding at a time. A side write port preloads the image, and a performance counter tracks served fetches. It sits between the IFU and the simulated SoC memory, standing in for an SRAM/flash controller.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (word = 4 bytes)
DEPTH_LOG2, 12, log2 of word count (4096 words)
BASE, 32'h8000_0000, first byte address mapped
LATENCY, 3, cycles from accept to rvalid; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
araddr  in  ADDR_W  fetch byte address, held by IFU while arvalid
arvalid  in  1  fetch request, level
rdata  out  DATA_W  fetched word, valid only with rvalid
rvalid  out  1  one-cycle response pulse
rerr  out  1  qualifies rvalid: address out of range
wen  in  1  preload write enable
waddr  in  ADDR_W  preload byte address
wdata  in  DATA_W  preload word
busy  out  1  high in any state other than IDLE
fetch_cnt  out  32  number of rvalid pulses since reset

Behaviour:
- Reset: state=IDLE; rvalid=0, rerr=0, rdata=0, busy=0, fetch_cnt=0. Memory array is not cleared.
- Reset mid-operation aborts the in-flight request. No rvalid is issued for it.
- Word index = (addr - BASE) >> 2, using bits [DEPTH_LOG2+1:2] of the offset. addr[1:0] is ignored (no misalign fault).
- In range: BASE <= addr < BASE + 4*2^DEPTH_LOG2, with unsigned compare on ADDR_W bits.
- FSM states: IDLE, WAIT, RESP, GAP.
  - IDLE: if arvalid, accept at cycle T. Latch the address, snapshot the memory word and the range flag, and load cnt = LATENCY-1. Next state is RESP if LATENCY==1, else WAIT.
  - WAIT: cnt decrements each cycle. When cnt==1, next state is RESP. Exactly LATENCY-1 cycles are spent in WAIT.
  - RESP: rvalid=1 for exactly this cycle, which is cycle T+LATENCY. Registered outputs:
    - rdata = snapshot if in range, else 0.
    - rerr = !in_range.
    - fetch_cnt increments by 1 (wraps at 2^32).
    - Next state is GAP.
  - GAP: one turnaround cycle. arvalid is ignored because the IFU may still hold the old request. Next state is IDLE. Earliest next accept is T+LATENCY+2.
- araddr changes or arvalid drops during WAIT/RESP are ignored. The latched request completes; there is no cancel.
- Outside RESP: rvalid=0 and rerr=0. rdata holds its last value.
- Preload write:
  - If wen, mem[index(waddr)] <= wdata at the clock edge.
  - Out-of-range waddr is dropped silently.
  - Writes are accepted in every state.
- Write/read collision in the accept cycle (same word): read-before-write, so the old word is returned.
- A write to the latched word during WAIT does not change the pending rdata, because the data was snapshotted at accept.
- LATENCY outside 1..15: elaboration error.

Test Plan:
- Reset then preload mem[0]=32'h0000_0413 via wen/waddr=8000_0000. Hold arvalid at T=10 with araddr=8000_0000 -> rvalid only at cycle 13, rdata=0000_0413, rerr=0, fetch_cnt=1. No accept before cycle 15.
- Back-to-back with arvalid held high and araddr stepping 8000_0000, 8000_0004 after each rvalid -> responses at 13 and 18, period LATENCY+2. fetch_cnt=2.
- araddr=7FFF_FFFC and araddr=8000_4000 -> rvalid with rerr=1, rdata=0. Counter still increments.
- Accept 8000_0008 while wen writes DEAD_BEEF to the same word in the same cycle -> old word returned. A second fetch returns DEAD_BEEF.
- araddr changes to 8000_0010 during WAIT -> response carries the data of the originally latched address.
- Assert rst at T+1 mid-request -> no rvalid. busy=0 next cycle, fetch_cnt=0, preloaded data intact. A new request succeeds. Repeat the first test with LATENCY=1 -> rvalid at T+1.

Source files
------------

// File: rtl/ysyx_ifu_sram_responder.sv
// ysyx_ifu_sram_responder: fixed-latency read-only fetch responder with preload port
// and served-fetch counter, one outstanding request at a time.
module ysyx_ifu_sram_responder #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
    parameter int                LATENCY    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rerr,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [31:0]       fetch_cnt
);
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

    state_t              r_state, w_next;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0]   r_snap, r_rdata, w_resp_data;
    logic                r_inr;
    logic [31:0]         r_fcnt;
    logic [ADDR_W-1:0]   w_rword, w_wword;
    logic                w_rinr, w_winr, w_accept;
    logic [DEPTH_LOG2-1:0] w_ridx, w_widx;

    // Word offsets from BASE; anything beyond the array depth is out of range.
    assign w_rword = (araddr - BASE) >> 2;
    assign w_wword = (waddr - BASE) >> 2;
    assign w_rinr  = (w_rword >> DEPTH_LOG2) == '0;
    assign w_winr  = (w_wword >> DEPTH_LOG2) == '0;
    assign w_ridx  = w_rword[DEPTH_LOG2-1:0];
    assign w_widx  = w_wword[DEPTH_LOG2-1:0];
    assign w_accept = r_state == S_IDLE && arvalid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (arvalid) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP: w_next = S_GAP;
            default: w_next = S_IDLE;
        endcase
        // With LATENCY==1 the response is formed straight from the array in the accept cycle.
        w_resp_data = (r_state == S_IDLE) ? (w_rinr ? r_mem[w_ridx] : '0)
                                          : (r_inr ? r_snap : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_cnt <= 4'(LATENCY - 1);
            else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
            if (w_next == S_RESP) begin
                r_rdata <= w_resp_data;
                r_fcnt  <= r_fcnt + 32'd1;
            end
        end
    end

    // Snapshot reads the pre-write word, giving read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_snap <= r_mem[w_ridx];
            r_inr  <= w_rinr;
        end
        if (wen && w_winr) r_mem[w_widx] <= wdata;
    end

    assign rvalid    = r_state == S_RESP;
    assign rerr      = r_state == S_RESP && !r_inr;
    assign rdata     = r_rdata;
    assign busy      = r_state != S_IDLE;
    assign fetch_cnt = r_fcnt;
endmodule

// File: tb/tb_ysyx_ifu_sram_responder.sv
// tb_ysyx_ifu_sram_responder: directed plus randomized fetches against a memory-image model,
// one instance with LATENCY=3 and one with LATENCY=1.
module tb_ysyx_ifu_sram_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        arvalid = 1'b0, arvalid1 = 1'b0, wen = 1'b0;
    logic [31:0] araddr = '0, waddr = '0, wdata = '0;
    logic [31:0] rdata, rdata1, fcnt, fcnt1;
    logic        rvalid, rvalid1, rerr, rerr1, busy, busy1;
    int          errors = 0, checks = 0;
    logic [31:0] cnt0 = 0, cnt1 = 0;
    logic [31:0] mm [int];

    always #5 clk = ~clk;

    ysyx_ifu_sram_responder #(.LATENCY(3)) dut (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .rdata(rdata),
        .rvalid(rvalid), .rerr(rerr), .wen(wen), .waddr(waddr), .wdata(wdata),
        .busy(busy), .fetch_cnt(fcnt));

    ysyx_ifu_sram_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid1), .rdata(rdata1),
        .rvalid(rvalid1), .rerr(rerr1), .wen(wen), .waddr(waddr), .wdata(wdata),
        .busy(busy1), .fetch_cnt(fcnt1));

    function automatic bit inr(input logic [31:0] a);
        return 64'(a) >= 64'(BASE) && 64'(a) < 64'(BASE) + 64'd16384;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        if (inr(a)) mm[widx(a)] = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    // mode 0: plain; 1: same-word write in accept cycle; 2: address change, arvalid drop and write in WAIT
    task automatic fetch(input logic [31:0] a, input bit one, input int mode, input string tag);
        logic [31:0] ed;
        bit ee;
        int n;
        ee = !inr(a);
        ed = ee ? 32'h0 : mm[widx(a)];
        araddr = a;
        if (one) arvalid1 = 1'b1; else arvalid = 1'b1;
        if (mode == 1) begin
            wen = 1'b1; waddr = a; wdata = 32'hDEAD_BEEF; mm[widx(a)] = 32'hDEAD_BEEF;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            wen = 1'b0;
            if (mode == 2 && n == 1) begin
                araddr = a + 32'h10; arvalid = 1'b0;
                wen = 1'b1; waddr = a; wdata = ~ed; mm[widx(a)] = ~ed;
            end
        end while (!(one ? rvalid1 : rvalid) && n < 20);
        if (one) cnt1++; else cnt0++;
        chk({tag, " latency"}, n, one ? 1 : 3);
        chk({tag, " rdata"}, one ? rdata1 : rdata, ed);
        chk({tag, " rerr"}, 32'(one ? rerr1 : rerr), 32'(ee));
        chk({tag, " fetch_cnt"}, one ? fcnt1 : fcnt, one ? cnt1 : cnt0);
        @(negedge clk);
        chk({tag, " gap rvalid"}, 32'(one ? rvalid1 : rvalid), 0);
        chk({tag, " gap busy"}, 32'(one ? busy1 : busy), 1);
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(one ? busy1 : busy), 0);
        chk({tag, " idle rerr"}, 32'(one ? rerr1 : rerr), 0);
    endtask

    initial begin
        logic [31:0] a;
        int seen;
        repeat (3) @(negedge clk);
        chk("reset rvalid", 32'(rvalid), 0);
        chk("reset rerr", 32'(rerr), 0);
        chk("reset rdata", rdata, 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset fetch_cnt", fcnt, 0);
        rst = 1'b0;
        write(BASE, 32'h0000_0413);
        for (int i = 1; i < 16; i++) write(BASE + 32'(4 * i), $urandom);
        write(BASE + 32'h4000, 32'h1234_5678);
        write(32'h7FFF_FFFC, 32'h8765_4321);
        fetch(BASE, 1'b0, 0, "first");
        fetch(BASE, 1'b0, 0, "b2b0");
        fetch(BASE + 32'h4, 1'b0, 0, "b2b1");
        arvalid = 1'b0;
        fetch(32'h7FFF_FFFC, 1'b0, 0, "below");
        fetch(32'h8000_4000, 1'b0, 0, "above");
        arvalid = 1'b0;
        fetch(BASE + 32'h8, 1'b0, 1, "collide");
        fetch(BASE + 32'h8, 1'b0, 0, "after_collide");
        fetch(BASE + 32'hC, 1'b0, 2, "wait_change");
        arvalid = 1'b0;
        fetch(BASE + 32'hC, 1'b0, 0, "after_wait_write");
        arvalid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0)
                a = $urandom_range(0, 1) ? BASE - 32'($urandom_range(1, 64))
                                         : BASE + 32'h4000 + 32'($urandom_range(0, 64));
            else
                a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) write(BASE + 32'(4 * $urandom_range(1, 15)), $urandom);
            fetch(a, 1'($urandom_range(0, 1)), 0, "random");
            arvalid = 1'b0; arvalid1 = 1'b0;
        end
        araddr = BASE; arvalid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; arvalid = 1'b0;
        cnt0 = 0; cnt1 = 0;
        chk("abort busy", 32'(busy), 0);
        chk("abort fetch_cnt", fcnt, 0);
        chk("abort rdata", rdata, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rvalid) seen++;
            @(negedge clk);
        end
        chk("abort no rvalid", seen, 0);
        fetch(BASE, 1'b0, 0, "post_reset");
        arvalid = 1'b0;
        fetch(BASE, 1'b1, 0, "lat1");
        fetch(BASE + 32'h4, 1'b1, 0, "lat1_b2b");
        arvalid1 = 1'b0;
        fetch(32'h8000_4000, 1'b1, 0, "lat1_oor");
        arvalid1 = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
